// File: rtl/trace_capture.sv
// Execution-trace recorder: captures {ts,pc,opcode,reg_val} on state change into a FWFT FIFO,
// counts drops and flags a stuck PC. Define TRACE_OPFILTER_EN to add an opcode match/mask filter.
module trace_capture #(
  parameter int PC_W        = 32,
  parameter int DATA_W      = 32,
  parameter int OP_W        = 6,
  parameter int TS_W        = 16,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 8,
  parameter int DROP_W      = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                en,
  input  logic                                clr,
  input  logic                                in_valid,
  input  logic [PC_W-1:0]                     pc,
  input  logic [OP_W-1:0]                     opcode,
  input  logic [DATA_W-1:0]                   reg_val,
`ifdef TRACE_OPFILTER_EN
  input  logic [OP_W-1:0]                     op_match,
  input  logic [OP_W-1:0]                     op_mask,
`endif
  input  logic                                rd_ready,
  output logic                                rd_valid,
  output logic [TS_W+PC_W+OP_W+DATA_W-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                full,
  output logic [DROP_W-1:0]                   drop_cnt,
  output logic                                halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] HALT_MAX = SW'(HALT_CYCLES);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] val;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt_q;
  logic [TS_W-1:0]   ts_q;
  logic [PC_W-1:0]   last_pc_q;
  logic [DATA_W-1:0] last_reg_q;
  logic              first_q;
  logic [DROP_W-1:0] drop_q;
  logic [SW-1:0]     stall_q, stall_nxt;
  logic              halted_q;

  logic changed, track, op_ok, cap, pop, push, drop;

  assign changed = first_q | (pc != last_pc_q) | (reg_val != last_reg_q);
  // track updates last_* even when the opcode filter rejects the entry
  assign track   = en & in_valid & changed & ~clr;
`ifdef TRACE_OPFILTER_EN
  assign op_ok   = ((opcode ^ op_match) & op_mask) == '0;
`else
  assign op_ok   = 1'b1;
`endif
  assign cap     = track & op_ok;
  assign full    = (cnt_q == FULL_CNT);
  assign rd_valid = (cnt_q != '0);
  assign pop     = rd_valid & rd_ready;
  assign push    = cap & (~full | pop);
  assign drop    = cap & full & ~pop;

  assign rd_data  = mem[rd_ptr];
  assign count    = cnt_q;
  assign drop_cnt = drop_q;
  assign halted   = halted_q;

  always_comb begin
    stall_nxt = stall_q;
    if (in_valid && (pc != last_pc_q))
      stall_nxt = '0;
    else if (in_valid && !first_q && (stall_q != HALT_MAX))
      stall_nxt = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ts: ts_q, pc: pc, op: opcode, val: reg_val};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
      stall_q    <= '0;
      halted_q   <= 1'b0;
      first_q    <= 1'b1;
      last_pc_q  <= '0;
      last_reg_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        cnt_q    <= '0;
        drop_q   <= '0;
        stall_q  <= '0;
        halted_q <= 1'b0;
        first_q  <= 1'b1;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
        if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
        stall_q  <= stall_nxt;
        halted_q <= halted_q | (stall_nxt == HALT_MAX);
        if (track) begin
          last_pc_q  <= pc;
          last_reg_q <= reg_val;
          first_q    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: directed steps plus random traffic against a queue model.
module tb_trace_capture;
  localparam int PC_W = 32, DATA_W = 32, OP_W = 6, TS_W = 8;
  localparam int DEPTH = 4, HALT_CYCLES = 8, DROP_W = 3;
  localparam int EW = TS_W + PC_W + OP_W + DATA_W;

  logic clk = 1'b0, reset = 1'b0;
  logic en = 1'b0, clr = 1'b0, in_valid = 1'b0, rd_ready = 1'b0;
  logic [PC_W-1:0] pc = '0;
  logic [OP_W-1:0] opcode = '0;
  logic [DATA_W-1:0] reg_val = '0;
`ifdef TRACE_OPFILTER_EN
  logic [OP_W-1:0] op_match = '0, op_mask = '0;
`endif
  logic rd_valid, full, halted;
  logic [EW-1:0] rd_data;
  logic [$clog2(DEPTH):0] count;
  logic [DROP_W-1:0] drop_cnt;

  trace_capture #(.PC_W(PC_W), .DATA_W(DATA_W), .OP_W(OP_W), .TS_W(TS_W), .DEPTH(DEPTH),
                  .HALT_CYCLES(HALT_CYCLES), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .in_valid(in_valid), .pc(pc),
    .opcode(opcode), .reg_val(reg_val),
`ifdef TRACE_OPFILTER_EN
    .op_match(op_match), .op_mask(op_mask),
`endif
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .full(full), .drop_cnt(drop_cnt), .halted(halted));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // reference state: FIFO as a queue, everything else as plain integers
  logic [EW-1:0]     mq[$];
  bit                m_first, m_halted;
  logic [PC_W-1:0]   m_last_pc;
  logic [DATA_W-1:0] m_last_reg;
  int                m_ts, m_stall, m_drop;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_first = 1; m_halted = 0; m_last_pc = '0; m_last_reg = '0;
    m_ts = 0; m_stall = 0; m_drop = 0;
  endtask

  task automatic model_update(input bit e, input bit c, input bit v, input logic [PC_W-1:0] p,
                              input logic [OP_W-1:0] o, input logic [DATA_W-1:0] r, input bit rr);
    bit pop, elig, ok;
    logic [TS_W-1:0] tsv;
    tsv = m_ts[TS_W-1:0];
    pop = (mq.size() != 0) && rr;
    if (c) begin
      mq.delete(); m_drop = 0; m_stall = 0; m_halted = 0; m_first = 1;
    end else begin
      elig = e && v && (m_first || p != m_last_pc || r != m_last_reg);
      ok = 1;
`ifdef TRACE_OPFILTER_EN
      ok = (((o ^ op_match) & op_mask) == 0);
`endif
      if (v && p != m_last_pc) m_stall = 0;
      else if (v && !m_first && m_stall < HALT_CYCLES) m_stall++;
      if (m_stall == HALT_CYCLES) m_halted = 1;
      if (pop) void'(mq.pop_front());
      if (elig && ok) begin
        if (mq.size() < DEPTH) mq.push_back({tsv, p, o, r});
        else if (m_drop < 2**DROP_W - 1) m_drop++;
      end
      if (elig) begin
        m_last_pc = p; m_last_reg = r; m_first = 0;
      end
    end
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic check_outputs();
    chk("rd_valid", 128'(rd_valid), 128'(mq.size() != 0));
    chk("count", 128'(count), 128'(mq.size()));
    chk("full", 128'(full), 128'(mq.size() == DEPTH));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    chk("halted", 128'(halted), 128'(m_halted));
    if (mq.size() != 0) chk("rd_data", 128'(rd_data), 128'(mq[0]));
  endtask

  task automatic step(input bit e, input bit c, input bit v, input logic [PC_W-1:0] p,
                      input logic [OP_W-1:0] o, input logic [DATA_W-1:0] r, input bit rr);
    en = e; clr = c; in_valid = v; pc = p; opcode = o; reg_val = r; rd_ready = rr;
    model_update(e, c, v, p, o, r, rr);
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [EW-1:0] saved;
    bit hold;
    #12;
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_drop", 128'(drop_cnt), 128'(0));
    chk("rst_halted", 128'(halted), 128'(0));
    release_reset();

    // first capture after one idle cycle carries ts=1
    step(1, 0, 0, 32'h0, 6'h00, 32'd0, 0);
    step(1, 0, 1, 32'h0, 6'h08, 32'd5, 0);
    chk("first_entry", 128'(rd_data), 128'({8'd1, 32'h0, 6'h08, 32'd5}));
    step(1, 0, 0, 32'h0, 6'h00, 32'd0, 1);

    // stuck PC: one entry, halted visible after the 9th sample
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 1, 32'h4, 6'h08, 32'd5, 0);
      if (i == 8) chk("halt_early", 128'(halted), 128'(0));
      if (i == 9) chk("halt_set", 128'(halted), 128'(1));
    end
    chk("halt_one_entry", 128'(count), 128'(1));
    step(1, 1, 1, 32'h4, 6'h08, 32'd5, 0);
    chk("clr_halted", 128'(halted), 128'(0));
    chk("clr_count", 128'(count), 128'(0));

    // overflow: 6 pushes into 4 slots
    for (int i = 0; i < 6; i++) step(1, 0, 1, 32'h100 + 4 * i, 6'h01, 32'd7, 0);
    chk("ovf_full", 128'(full), 128'(1));
    chk("ovf_count", 128'(count), 128'(4));
    chk("ovf_drop", 128'(drop_cnt), 128'(2));
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 6'h00, 32'd0, 1);

    // full with simultaneous pop and capture
    step(1, 1, 0, 32'h0, 6'h00, 32'd0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 32'h200 + 4 * i, 6'h02, 32'd1, 0);
    step(1, 0, 1, 32'h2F0, 6'h03, 32'd9, 1);
    chk("fullpop_count", 128'(count), 128'(4));
    chk("fullpop_drop", 128'(drop_cnt), 128'(0));
    saved = mq[$];
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 6'h00, 32'd0, 1);
    chk("fullpop_last", 128'(rd_data), 128'(saved));
    step(1, 0, 0, 32'h0, 6'h00, 32'd0, 1);

    // drop counter saturates
    for (int i = 0; i < 13; i++) step(1, 0, 1, 32'h300 + 4 * i, 6'h04, 32'd2, 0);
    chk("drop_sat", 128'(drop_cnt), 128'(7));
    step(1, 1, 0, 32'h0, 6'h00, 32'd0, 0);

    // en=0 freezes capture and last_*
    step(1, 0, 1, 32'h500, 6'h05, 32'd1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h600 + 4 * i, 6'h05, 32'd3, 0);
    step(1, 0, 1, 32'h500, 6'h05, 32'd1, 0);
    chk("en_off_count", 128'(count), 128'(1));
    step(1, 1, 0, 32'h0, 6'h00, 32'd0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      hold = ((i / 30) % 2) == 1;
      step($urandom_range(0, 7) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
           hold ? 32'h40 : 32'(4 * $urandom_range(0, 2)), 6'($urandom_range(0, 63)),
           hold ? 32'd0 : 32'($urandom_range(0, 1)), $urandom_range(0, 1) == 1);
    end

    // timestamp wrap after reset
    #2 reset = 1'b0;
    release_reset();
    for (int i = 0; i < 259; i++) step(1, 0, 0, 32'h0, 6'h00, 32'd0, 0);
    step(1, 0, 1, 32'h700, 6'h06, 32'd4, 0);
    chk("ts_wrap", 128'(rd_data[EW-1 -: TS_W]), 128'(3));
    for (int i = 0; i < 6; i++) step(1, 0, 1, 32'h800 + 4 * i, 6'h07, 32'd8, 0);
    reset = 1'b0;
    #1;
    chk("midrst_rd_valid", 128'(rd_valid), 128'(0));
    chk("midrst_count", 128'(count), 128'(0));
    chk("midrst_drop", 128'(drop_cnt), 128'(0));
    release_reset();
    step(1, 0, 0, 32'h0, 6'h00, 32'd0, 0);

`ifdef TRACE_OPFILTER_EN
    op_mask = 6'h3F; op_match = 6'h23;
    for (int i = 0; i < 8; i++)
      step(1, 0, 1, 32'h900 + 4 * i, (i % 2 == 0) ? 6'h23 : 6'h2B, 32'd1, 0);
    chk("filt_count", 128'(count), 128'(4));
    chk("filt_drop", 128'(drop_cnt), 128'(0));
    for (int i = 0; i < 4; i++) begin
      chk("filt_op", 128'(rd_data[DATA_W +: OP_W]), 128'(6'h23));
      step(1, 0, 0, 32'h0, 6'h00, 32'd0, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
Parametrised execution-trace recorder for the Mini-MIPS core. It replaces free-running console monitoring of register/PC/opcode with a hardware capture buffer. It records an entry only when the watched architectural state changes. Entries carry a cycle timestamp and are buffered in a first-word-fall-through FIFO, drained by a ready/valid reader (bench or debug UART). It also detects a halted core (PC stuck) and counts dropped entries.

Parameters:
PC_W, 32, program counter width
DATA_W, 32, watched register value width
OP_W, 6, opcode width
TS_W, 16, timestamp counter width
DEPTH, 16, FIFO entries (power of two, >=2)
HALT_CYCLES, 8, consecutive stuck-PC valid cycles before halted asserts
DROP_W, 8, dropped-entry counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  capture enable
clr  in  1  synchronous clear of FIFO, drop counter, halt logic
in_valid  in  1  core state sample valid this cycle
pc  in  PC_W  current program counter
opcode  in  OP_W  current opcode
reg_val  in  DATA_W  watched register value
rd_ready  in  1  reader accepts head entry
rd_valid  out  1  FIFO non-empty
rd_data  out  TS_W+PC_W+OP_W+DATA_W  head entry {ts,pc,opcode,reg_val}, MSB first
count  out  $clog2(DEPTH)+1  current occupancy
full  out  1  occupancy == DEPTH
drop_cnt  out  DROP_W  entries lost to full FIFO, saturating
halted  out  1  sticky halt flag

Behaviour:
- Reset (reset=0, async): FIFO empty; rd_valid=0, count=0, full=0, drop_cnt=0, halted=0, timestamp=0, first flag set, last_pc/last_reg=0. rd_data is don't-care while empty.
- Timestamp: free-running from reset release, +1 per clk, wraps modulo 2^TS_W. clr does not reset it.
- Capture condition (cap): en & in_valid & (first | pc!=last_pc | reg_val!=last_reg).
- On cap, last_pc/last_reg update and first clears. The entry contains the timestamp of the capture cycle.
- Push: cap & (!full | pop). When full and the reader pops in the same cycle, the push is accepted; count is unchanged.
- Drop: cap & full & !pop. drop_cnt increments and saturates at all-ones. last_pc/last_reg still update.
- Pop: rd_valid & rd_ready. FWFT: rd_data shows the head combinationally from storage. A pushed entry becomes visible the cycle after the push. Latency from cap to rd_valid is 1 cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count = pushes - pops.
- Halt detector: a stall counter increments on in_valid & pc==last_pc & !first. It resets to 0 on in_valid & pc!=last_pc. It holds when in_valid=0, and saturates at HALT_CYCLES. halted sets when the counter reaches HALT_CYCLES and is sticky until clr or reset. en does not gate the halt detector.
- clr (sync, highest priority after reset): empties the FIFO and zeroes drop_cnt, stall counter and halted. It sets first, and any same-cycle cap is ignored.
- en=0: no captures and last_* frozen; reads continue.
- Reset mid-operation: all state is lost immediately. No partial entry survives.

Optional Feature:
Macro TRACE_OPFILTER_EN.
- Defined: adds inputs op_match (OP_W) and op_mask (OP_W). cap additionally requires ((opcode ^ op_match) & op_mask)==0. Filtered cycles still update last_pc/last_reg and the halt logic.
- Undefined: ports absent; all opcodes eligible.

Test Plan:
- Reset, then in_valid=1 with pc=0x0, op=0x08, reg=5 for 1 cycle -> next cycle rd_valid=1, rd_data={ts=1,0x0,0x08,5}, count=1.
- Hold pc=0x4, reg=5 for 10 valid cycles (HALT_CYCLES=8) -> one entry only; halted=1 on the 9th cycle after the first capture; clr -> halted=0, count=0.
- DEPTH=4: 6 changing samples with rd_ready=0 -> full=1, count=4, drop_cnt=2; oldest 4 entries read back in order.
- Full FIFO with simultaneous cap and rd_ready=1 -> count stays 4, drop_cnt unchanged, new entry is last out.
- 2^TS_W+3 cycles after reset, capture -> ts field=3 (wrap); assert reset low mid-burst -> rd_valid=0 immediately, drop_cnt=0.
- TRACE_OPFILTER_EN, mask=0x3F, match=0x23: alternate opcodes 0x23/0x2B with changing pc -> only 0x23 entries captured.
